// File: rtl/fg_dac_sequencer.sv
// Write sequencer for an external parallel DAC: post-reset clear pulse, power-down,
// framed active-low write strobe, programmable settle interval and dropped-sample accounting.
module fg_dac_sequencer #(
  parameter int BITWIDTH      = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int WR_LOW_CYCLES = 2,
  parameter int CLR_CYCLES    = 4,
  parameter int PSC_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [BITWIDTH-1:0]  sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  output logic [BITWIDTH-1:0]  dac_data_o,
  output logic                 dac_wr_n_o,
  output logic                 dac_clr_n_o,
  output logic                 dac_pd_n_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [7:0]           drop_count_o
);

  localparam int CW = (PSC_WIDTH > 16) ? PSC_WIDTH : 16;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_SETTLE
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [BITWIDTH-1:0] data_q;
  logic                wr_n_q;
  logic                clr_n_q;
  logic                pd_n_q;
  logic                ovr_q;
  logic [7:0]          drop_q;

  logic accept;
  logic drop;

  assign sample_ready_o = (state_q == S_IDLE) && enable_i;
  assign accept         = sample_valid_i && sample_ready_o;
  // Valid while disabled is not a drop; only an enabled, unready offer is lost.
  assign drop           = sample_valid_i && enable_i && !sample_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      data_q  <= '0;
      wr_n_q  <= 1'b1;
      clr_n_q <= 1'b0;
      pd_n_q  <= 1'b1;
      ovr_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      pd_n_q <= !(!enable_i && (state_q == S_IDLE));
      ovr_q  <= drop;
      if (drop && (drop_q != '1)) drop_q <= drop_q + 8'd1;

      case (state_q)
        // cnt_q counts edges since reset release; clr_n stays low for CLR_CYCLES of them.
        S_INIT: begin
          if (cnt_q == CW'(CLR_CYCLES)) begin
            state_q <= S_IDLE;
            clr_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_IDLE: begin
          if (accept) begin
            data_q  <= sample_i;
            cnt_q   <= CW'(SETUP_CYCLES);
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == CW'(1)) begin
            state_q <= S_STROBE;
            wr_n_q  <= 1'b0;
            cnt_q   <= CW'(WR_LOW_CYCLES);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_STROBE: begin
          if (cnt_q == CW'(1)) begin
            state_q <= S_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          cnt_q   <= CW'(psc_i);
          state_q <= (psc_i != '0) ? S_SETTLE : S_IDLE;
        end
        S_SETTLE: begin
          if (cnt_q == CW'(1)) state_q <= S_IDLE;
          else                 cnt_q   <= cnt_q - CW'(1);
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign dac_data_o   = data_q;
  assign dac_wr_n_o   = wr_n_q;
  assign dac_clr_n_o  = clr_n_q;
  assign dac_pd_n_o   = pd_n_q;
  assign busy_o       = (state_q != S_IDLE);
  assign overrun_o    = ovr_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_fg_dac_sequencer.sv
// Bench for fg_dac_sequencer: timeline model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_fg_dac_sequencer;
  localparam int BW  = 8;
  localparam int S   = 1;
  localparam int W   = 2;
  localparam int CLR = 4;
  localparam int PW  = 16;
  localparam int NEVER = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic [PW-1:0] psc_i = '0;
  logic [BW-1:0] sample_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          sample_ready_o;
  logic [BW-1:0] dac_data_o;
  logic          dac_wr_n_o;
  logic          dac_clr_n_o;
  logic          dac_pd_n_o;
  logic          busy_o;
  logic          overrun_o;
  logic [7:0]    drop_count_o;

  fg_dac_sequencer #(
    .BITWIDTH(BW),
    .SETUP_CYCLES(S),
    .WR_LOW_CYCLES(W),
    .CLR_CYCLES(CLR),
    .PSC_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_i(enable_i),
    .psc_i(psc_i),
    .sample_i(sample_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o),
    .dac_data_o(dac_data_o),
    .dac_wr_n_o(dac_wr_n_o),
    .dac_clr_n_o(dac_clr_n_o),
    .dac_pd_n_o(dac_pd_n_o),
    .busy_o(busy_o),
    .overrun_o(overrun_o),
    .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Edges since reset release: cycle n is the interval after the n-th edge.
  int pcnt = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pcnt <= 0;
    else        pcnt <= pcnt + 1;

  int ovr_cnt = 0;
  always @(negedge clk)
    if (rst_n && overrun_o) ovr_cnt++;

  // Timeline model: tracks the cycle the sequencer is next idle, the strobe window
  // of the current write, the latched sample and the saturating drop tally.
  int         idle_at, wr_lo, wr_hi, hold_at, drops, n;
  logic [7:0] data_m;
  logic       ovr_m, pd_m, idle_m, rdy_m, drop_m, acc_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      idle_at = CLR + 1; wr_lo = -1; wr_hi = -2; hold_at = -1;
      drops = 0; data_m = '0; ovr_m = 1'b0; pd_m = 1'b1;
      chk("rst_ready", sample_ready_o, 0);
      chk("rst_busy",  busy_o, 1);
      chk("rst_wr_n",  dac_wr_n_o, 1);
      chk("rst_clr_n", dac_clr_n_o, 0);
      chk("rst_pd_n",  dac_pd_n_o, 1);
      chk("rst_data",  dac_data_o, 0);
      chk("rst_ovr",   overrun_o, 0);
      chk("rst_count", drop_count_o, 0);
    end else begin
      n      = pcnt;
      idle_m = (n >= idle_at);
      rdy_m  = idle_m && enable_i;
      chk("ready", sample_ready_o, rdy_m);
      chk("busy",  busy_o, !idle_m);
      chk("clr_n", dac_clr_n_o, n >= CLR + 1);
      chk("wr_n",  dac_wr_n_o, !(n >= wr_lo && n <= wr_hi));
      chk("data",  dac_data_o, data_m);
      chk("pd_n",  dac_pd_n_o, pd_m);
      chk("overrun", overrun_o, ovr_m);
      chk("drop_count", drop_count_o, drops);
      drop_m = sample_valid_i && enable_i && !rdy_m;
      acc_m  = sample_valid_i && rdy_m;
      if (n == hold_at) idle_at = n + 1 + int'(psc_i);
      if (acc_m) begin
        data_m  = sample_i;
        wr_lo   = n + 1 + S;
        wr_hi   = n + S + W;
        hold_at = n + 1 + S + W;
        idle_at = NEVER;
      end
      ovr_m = drop_m;
      if (drop_m && drops < 255) drops++;
      pd_m = !(!enable_i && idle_m);
    end
  end

  // All stimulus tasks enter and leave at posedge+1 except neg_of.
  task automatic goto(input int c);
    int g = 0;
    while (pcnt < c && g < 5000) begin @(posedge clk); #1; g++; end
  endtask

  task automatic neg_of(input int c);
    int g = 0;
    do begin @(negedge clk); g++; end while (pcnt < c && g < 5000);
    if (pcnt != c) chk("neg_sync", pcnt, c);
  endtask

  task automatic wait_ready(output int t);
    t = -1;
    for (int i = 0; i < 600; i++) begin
      if (sample_ready_o) begin t = pcnt; return; end
      @(posedge clk); #1;
    end
    chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (3) @(posedge clk); #1; rst_n = 1'b1;
  endtask

  int t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enable_i = 1'b1;
    repeat (3) @(posedge clk); #1; rst_n = 1'b1;

    // Reset release; valid in the INIT->IDLE cycle is dropped
    goto(4); sample_valid_i = 1'b1;
    @(negedge clk);
    chk("init_clr_low_c4", dac_clr_n_o, 0);
    chk("init_ready_c4", sample_ready_o, 0);
    @(posedge clk); #1; sample_valid_i = 1'b0;
    @(negedge clk);
    chk("init_clr_high_c5", dac_clr_n_o, 1);
    chk("init_ready_c5", sample_ready_o, 1);
    chk("init_wr_n_c5", dac_wr_n_o, 1);
    chk("init_drop_ovr", overrun_o, 1);
    chk("init_drop_cnt", drop_count_o, 1);
    @(posedge clk); #1;

    // Single write, psc 0
    wait_ready(t);
    sample_i = 8'hA5; sample_valid_i = 1'b1;
    @(posedge clk); #1; sample_valid_i = 1'b0;
    neg_of(t + 1); chk("sw_data_t1", dac_data_o, 8'hA5); chk("sw_wr_t1", dac_wr_n_o, 1);
    neg_of(t + 2); chk("sw_wr_t2", dac_wr_n_o, 0);
    neg_of(t + 3); chk("sw_wr_t3", dac_wr_n_o, 0);
    neg_of(t + 4); chk("sw_wr_t4", dac_wr_n_o, 1); chk("sw_ready_t4", sample_ready_o, 0);
    neg_of(t + 5); chk("sw_ready_t5", sample_ready_o, 1);
    @(posedge clk); #1;

    // Continuous valid, psc 3: accepts every 8 cycles, 7 drops per gap
    do_reset();
    wait_ready(t);
    psc_i = 16'd3; ovr_cnt = 0;
    sample_valid_i = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      sample_i = 8'(k * 17 + 3);
      if (k == 13) psc_i = 16'd0;
      if (k == 7 || k == 8 || k == 16) begin
        @(negedge clk);
        chk($sformatf("cont_ready_k%0d", k), sample_ready_o, k != 7);
      end
      @(posedge clk); #1;
    end
    sample_valid_i = 1'b0;
    goto(t + 19);
    chk("cont_drop_cnt", drop_count_o, 14);
    chk("cont_ovr_pulses", ovr_cnt, 14);

    // Saturation: long settle with valid held high
    wait_ready(t);
    psc_i = 16'd320; sample_valid_i = 1'b1;
    repeat (324) begin sample_i = sample_i + 8'd1; @(posedge clk); #1; end
    sample_valid_i = 1'b0; psc_i = 16'd0;
    wait_ready(t);
    chk("sat_count", drop_count_o, 255);
    repeat (3) @(posedge clk); #1;
    chk("sat_count_hold", drop_count_o, 255);

    // enable falls during STROBE: write completes, then power-down, valid ignored
    wait_ready(t);
    sample_i = 8'h3C; sample_valid_i = 1'b1;
    @(posedge clk); #1; sample_valid_i = 1'b0;
    goto(t + 2); enable_i = 1'b0;
    neg_of(t + 2); chk("en_wr_t2", dac_wr_n_o, 0);
    neg_of(t + 3); chk("en_wr_t3", dac_wr_n_o, 0);
    neg_of(t + 4); chk("en_wr_t4", dac_wr_n_o, 1); chk("en_pd_t4", dac_pd_n_o, 1);
    neg_of(t + 5); chk("en_busy_t5", busy_o, 0); chk("en_ready_t5", sample_ready_o, 0);
    @(posedge clk); #1; sample_valid_i = 1'b1;
    @(negedge clk); chk("en_pd_t6", dac_pd_n_o, 0);
    @(posedge clk); #1; sample_valid_i = 1'b0;
    @(negedge clk); chk("en_ovr_t7", overrun_o, 0); chk("en_data_t7", dac_data_o, 8'h3C);
    @(posedge clk); #1; enable_i = 1'b1;
    @(posedge clk); #1;

    // Reset while wr_n is low
    wait_ready(t);
    sample_i = 8'h5A; sample_valid_i = 1'b1;
    @(posedge clk); #1; sample_valid_i = 1'b0;
    for (int i = 0; i < 20 && dac_wr_n_o; i++) begin @(posedge clk); #1; end
    chk("mid_wr_low_seen", dac_wr_n_o, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_n", dac_wr_n_o, 1);
    chk("mid_rst_data", dac_data_o, 0);
    chk("mid_rst_clr_n", dac_clr_n_o, 0);
    repeat (3) @(posedge clk); #1; rst_n = 1'b1;
    neg_of(4); chk("rel_clr_c4", dac_clr_n_o, 0); chk("rel_wr_c4", dac_wr_n_o, 1);
    neg_of(5); chk("rel_clr_c5", dac_clr_n_o, 1); chk("rel_ready_c5", sample_ready_o, 1);
    chk("rel_count", drop_count_o, 0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
